mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester and the load/store requester of the 5-stage pipeline core.
- Arbitrates per cycle and forwards the winning request to the memory.
- Tracks outstanding reads in an in-order ID FIFO and routes each read response back to the requester that issued it.
- Data access normally wins; a starvation counter guarantees forward progress for fetch.

Parameters:
- AW, 32, address width
- DW, 32, data width
- OUTSTANDING, 2, max in-flight reads (ID FIFO depth, power of 2, >=1)
- MAX_WAIT, 4, consecutive lost cycles after which fetch gets priority (>=1)

Ports:
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch read request; held with if_addr until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DW  fetch read data
- d_req  in  1  data request; held with all d_* fields until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_wstrb  in  DW/8  byte write strobes
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid
- d_rdata  out  DW  data read data
- mem_req  out  1  request to memory
- mem_we  out  1  write enable to memory
- mem_wstrb  out  DW/8  strobes to memory
- mem_addr  out  AW  address to memory
- mem_wdata  out  DW  write data to memory
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  read response valid (in order, >=1 cycle after accept)
- mem_rdata  in  DW  read response data
- resp_err  out  1  sticky: a response arrived with no outstanding read

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ID FIFO empty; wait_cnt=0; resp_err=0.
  - All gnt and rvalid outputs 0; mem_req=0.
- Eligibility:
  - A read is eligible only if the FIFO is not full, or a pop occurs in the same cycle (pop-then-push allowed at full).
  - Writes are always eligible; they never enter the FIFO and produce no response.
- Arbitration (combinational each cycle):
  - Data wins when both requesters are eligible, unless wait_cnt==MAX_WAIT, in which case fetch wins.
  - A lone eligible requester always wins.
- Memory side:
  - mem_req=1 whenever a winner exists; mem_we/mem_wstrb/mem_addr/mem_wdata come from the winner.
  - For a fetch winner: mem_we=0, mem_wstrb=0, mem_wdata=0.
- Grant: winner's gnt = mem_req & mem_ready. Zero-cycle: gnt is combinational from req and mem_ready. At most one gnt per cycle.
- FIFO:
  - On a granted read, push the ID (0 = fetch, 1 = data).
  - On mem_rvalid with FIFO non-empty, pop the head ID.
  - if_rvalid = mem_rvalid & head==0; d_rvalid = mem_rvalid & head==1.
  - Both rdata outputs = mem_rdata (pass-through, zero latency).
- Orphan response: mem_rvalid with FIFO empty (including a push in the same cycle) is dropped, no rvalid is raised, and resp_err is set until reset.
- Starvation counter wait_cnt (saturating at MAX_WAIT):
  - Increments each cycle if_req=1 and if_gnt=0.
  - Clears on if_gnt, and when if_req=0.
- Ordering: responses are returned strictly in issue order across both requesters; a write granted between two reads does not disturb the FIFO.
- Reset mid-operation: the FIFO is cleared; responses to pre-reset reads arrive as orphans → dropped, resp_err=1.
- Requester protocol: deasserting req before gnt is legal; a new arbitration decision is made every cycle.
- Storage: all state is in flip-flops; no latches.

Test Plan:
- Reset, then if_req=1, if_addr=0x100, mem_ready=1 → if_gnt=1, mem_addr=0x100, mem_we=0; mem_rvalid=1, mem_rdata=0xDEADBEEF next cycle → if_rvalid=1, if_rdata=0xDEADBEEF, d_rvalid=0.
- Both requesters active, d_addr=0x200 read, mem_ready=1 → d_gnt=1, if_gnt=0, FIFO head=1; fetch is granted the following cycle.
- Continuous d_req writes plus if_req, MAX_WAIT=4 → if_gnt=0 for 4 cycles, if_gnt=1 on the 5th cycle, wait_cnt returns to 0.
- OUTSTANDING=2; fetch read and data read granted, no responses → third read req gets no gnt; d_we=1 write at 0x300, wstrb=4'b0011 → d_gnt=1, mem_wstrb=4'b0011; two responses 0x11, 0x22 → if_rdata=0x11, then d_rdata=0x22.
- FIFO full with mem_rvalid=1 and if_req=1 in the same cycle → if_gnt=1, pop and push together, occupancy stays 2.
- Issue a read, pulse rst_n=0, then mem_rvalid=1 → no rvalid output, resp_err=1, held until the next reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data normally wins arbitration. A saturating wait counter hands priority to
// fetch after MAX_WAIT lost cycles. Read IDs are queued in order, and each
// response is steered back to the requester that issued the read.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int OUTSTANDING = 2,
  parameter int MAX_WAIT    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_wstrb,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            resp_err
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL  = CW'(OUTSTANDING);
  localparam logic [WW-1:0] WMAX  = WW'(MAX_WAIT);
  localparam logic [PW-1:0] PLAST = PW'(OUTSTANDING - 1);

  // ID FIFO: 0 = fetch, 1 = data
  logic [OUTSTANDING-1:0] id_q, id_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic                   err_q, err_d;

  logic pop, push, rd_ok, if_elig, d_elig, sel_if, sel_d, head;

  // Arbitration, memory-side mux, grants and response steering.
  // Everything is qualified by rst_n so that outputs are quiet while reset
  // is asserted, even if requesters are still driving.
  always_comb begin
    pop       = rst_n & mem_rvalid & (cnt_q != '0);
    // a pop in the same cycle frees a slot, so a read may push at full
    rd_ok     = (cnt_q != FULL) | pop;
    if_elig   = rst_n & if_req & rd_ok;
    d_elig    = rst_n & d_req & (d_we | rd_ok);
    sel_if    = if_elig & (~d_elig | (wait_q == WMAX));
    sel_d     = d_elig & ~sel_if;
    mem_req   = sel_if | sel_d;
    mem_we    = 1'b0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sel_d) begin
      mem_we    = d_we;
      mem_wstrb = d_wstrb;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (sel_if) begin
      mem_addr  = if_addr;
    end
    if_gnt    = sel_if & mem_ready;
    d_gnt     = sel_d & mem_ready;
    push      = if_gnt | (d_gnt & ~d_we);
    head      = id_q[rd_ptr_q];
    if_rvalid = pop & ~head;
    d_rvalid  = pop & head;
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
    resp_err  = err_q;
  end

  // Next state for the ID FIFO, the starvation counter and the sticky error.
  always_comb begin
    id_d     = id_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    wait_d   = '0;
    // a response with nothing outstanding is dropped and flagged
    err_d    = err_q | (mem_rvalid & (cnt_q == '0));
    if (push) begin
      id_d[wr_ptr_q] = d_gnt;
      wr_ptr_d = (wr_ptr_q == PLAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop)
      rd_ptr_d = (rd_ptr_q == PLAST) ? '0 : rd_ptr_q + PW'(1);
    if (if_req & ~if_gnt)
      wait_d = (wait_q == WMAX) ? WMAX : wait_q + WW'(1);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      id_q     <= id_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. It runs directed scenarios plus randomized
// traffic and compares every cycle against a queue-based reference model.
module tb_mem_port_arbiter;
  localparam int OUTSTANDING = 2;
  localparam int MAX_WAIT    = 4;

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
  } drv_t;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        if_gnt;
    logic        d_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        resp_err;
  } out_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req, d_req, d_we, mem_ready, mem_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0] d_wstrb;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, resp_err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;

  int n_vec = 0, n_err = 0;

  // reference model state: in-order list of outstanding read owners
  int mq[$];
  int wcnt;
  bit err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .OUTSTANDING(OUTSTANDING), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .resp_err(resp_err)
  );

  task automatic drive(input drv_t v);
    if_req = v.if_req; if_addr = v.if_addr; d_req = v.d_req; d_we = v.d_we;
    d_wstrb = v.d_wstrb; d_addr = v.d_addr; d_wdata = v.d_wdata;
    mem_ready = v.mem_ready; mem_rvalid = v.mem_rvalid; mem_rdata = v.mem_rdata;
  endtask

  // memory-side fields are don't-care while mem_req is low
  function automatic out_t sample();
    out_t o;
    o = '0;
    o.mem_req = mem_req;
    if (mem_req === 1'b1) begin
      o.mem_we = mem_we; o.mem_wstrb = mem_wstrb; o.mem_addr = mem_addr; o.mem_wdata = mem_wdata;
    end
    o.if_gnt = if_gnt; o.d_gnt = d_gnt; o.if_rvalid = if_rvalid; o.if_rdata = if_rdata;
    o.d_rvalid = d_rvalid; o.d_rdata = d_rdata; o.resp_err = resp_err;
    return o;
  endfunction

  // Expected outputs for this cycle from the model state and the inputs.
  function automatic out_t model_eval(drv_t v);
    out_t e;
    bit have_resp, room, f_ok, d_ok;
    int win; // 0 none, 1 fetch, 2 data
    e = '0;
    have_resp = v.mem_rvalid && mq.size() > 0;
    room = (mq.size() < OUTSTANDING) || have_resp;
    f_ok = v.if_req && room;
    d_ok = v.d_req && (v.d_we || room);
    if (f_ok && d_ok) win = (wcnt >= MAX_WAIT) ? 1 : 2;
    else if (f_ok)    win = 1;
    else if (d_ok)    win = 2;
    else              win = 0;
    e.mem_req = (win != 0);
    if (win == 1) e.mem_addr = v.if_addr;
    if (win == 2) begin
      e.mem_we = v.d_we; e.mem_wstrb = v.d_wstrb; e.mem_addr = v.d_addr; e.mem_wdata = v.d_wdata;
    end
    e.if_gnt = (win == 1) && v.mem_ready;
    e.d_gnt  = (win == 2) && v.mem_ready;
    e.if_rvalid = have_resp && mq[0] == 0;
    e.d_rvalid  = have_resp && mq[0] == 1;
    e.if_rdata = v.mem_rdata;
    e.d_rdata  = v.mem_rdata;
    e.resp_err = err;
    return e;
  endfunction

  task automatic model_update(input drv_t v, input out_t e);
    if (v.mem_rvalid && mq.size() == 0) err = 1;
    if (v.mem_rvalid && mq.size() > 0) void'(mq.pop_front());
    if (e.if_gnt) mq.push_back(0);
    if (e.d_gnt && !v.d_we) mq.push_back(1);
    if (v.if_req && !e.if_gnt) wcnt = (wcnt < MAX_WAIT) ? wcnt + 1 : MAX_WAIT;
    else wcnt = 0;
  endtask

  task automatic model_reset();
    mq.delete(); wcnt = 0; err = 0;
  endtask

  // One clock cycle: apply, settle, sample, advance the model, cross the edge.
  task automatic step(input drv_t v, output out_t o, output out_t e);
    drive(v);
    #2;
    e = model_eval(v);
    o = sample();
    model_update(v, e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive('0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    drv_t v;
    out_t o;
    v = '0; v.if_req = 1; v.if_addr = 32'h40; v.d_req = 1; v.d_addr = 32'h80;
    v.mem_ready = 1; v.mem_rvalid = 1; v.mem_rdata = 32'h5;
    rst_n = 1'b0;
    drive(v);
    #2;
    o = sample();
    n_vec++;
    if ({o.mem_req, o.if_gnt, o.d_gnt, o.if_rvalid, o.d_rvalid, o.resp_err} !== 6'b0) begin
      n_err++; $display("FAIL reset_outputs got %b want 000000",
        {o.mem_req, o.if_gnt, o.d_gnt, o.if_rvalid, o.d_rvalid, o.resp_err});
    end
    do_reset();
  endtask

  task automatic test_fetch_basic();
    drv_t v;
    out_t o, e;
    do_reset();
    v = '0; v.if_req = 1; v.if_addr = 32'h100; v.mem_ready = 1;
    step(v, o, e);
    n_vec++;
    if (o !== e || o.if_gnt !== 1'b1 || o.mem_addr !== 32'h100 || o.mem_we !== 1'b0) begin
      n_err++; $display("FAIL fetch_grant got %h want %h", o, e);
    end
    v = '0; v.mem_rvalid = 1; v.mem_rdata = 32'hDEADBEEF;
    step(v, o, e);
    n_vec++;
    if (o !== e || o.if_rvalid !== 1'b1 || o.if_rdata !== 32'hDEADBEEF || o.d_rvalid !== 1'b0) begin
      n_err++; $display("FAIL fetch_resp got %h want %h", o, e);
    end
  endtask

  task automatic test_data_priority();
    drv_t v;
    out_t o, e;
    do_reset();
    v = '0; v.if_req = 1; v.if_addr = 32'h104; v.d_req = 1; v.d_addr = 32'h200; v.mem_ready = 1;
    step(v, o, e);
    n_vec++;
    if (o !== e || o.d_gnt !== 1'b1 || o.if_gnt !== 1'b0 || o.mem_addr !== 32'h200) begin
      n_err++; $display("FAIL data_wins got %h want %h", o, e);
    end
    v.d_req = 0;
    step(v, o, e);
    n_vec++;
    if (o !== e || o.if_gnt !== 1'b1) begin
      n_err++; $display("FAIL fetch_next got %h want %h", o, e);
    end
    // first response belongs to data, second to fetch
    for (int i = 0; i < 2; i++) begin
      v = '0; v.mem_rvalid = 1; v.mem_rdata = 32'hA0 + i;
      step(v, o, e);
      n_vec++;
      if (o !== e || o.d_rvalid !== (i == 0) || o.if_rvalid !== (i == 1)) begin
        n_err++; $display("FAIL prio_resp%0d got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_starvation();
    drv_t v;
    out_t o, e;
    do_reset();
    v = '0; v.if_req = 1; v.if_addr = 32'h180; v.d_req = 1; v.d_we = 1;
    v.d_wstrb = 4'hF; v.d_addr = 32'h400; v.d_wdata = 32'h12345678; v.mem_ready = 1;
    for (int c = 1; c <= 6; c++) begin
      step(v, o, e);
      n_vec++;
      // fetch wins on cycle 5 only; the counter is back to 0 on cycle 6
      if (o !== e || o.if_gnt !== (c == 5) || o.d_gnt !== (c != 5)) begin
        n_err++; $display("FAIL starve_c%0d got %h want %h", c, o, e);
      end
    end
  endtask

  task automatic test_full();
    drv_t v;
    out_t o, e;
    do_reset();
    v = '0; v.if_req = 1; v.if_addr = 32'h10; v.mem_ready = 1;
    step(v, o, e);
    v = '0; v.d_req = 1; v.d_addr = 32'h20; v.mem_ready = 1;
    step(v, o, e);
    n_vec++;
    if (o !== e || o.d_gnt !== 1'b1) begin
      n_err++; $display("FAIL full_fill got %h want %h", o, e);
    end
    v = '0; v.if_req = 1; v.if_addr = 32'h14; v.d_req = 1; v.d_addr = 32'h24; v.mem_ready = 1;
    step(v, o, e);
    n_vec++;
    if (o !== e || o.if_gnt !== 1'b0 || o.d_gnt !== 1'b0 || o.mem_req !== 1'b0) begin
      n_err++; $display("FAIL full_block got %h want %h", o, e);
    end
    v.d_we = 1; v.d_addr = 32'h300; v.d_wstrb = 4'b0011; v.d_wdata = 32'hCAFE;
    step(v, o, e);
    n_vec++;
    if (o !== e || o.d_gnt !== 1'b1 || o.mem_wstrb !== 4'b0011 || o.mem_we !== 1'b1) begin
      n_err++; $display("FAIL full_write got %h want %h", o, e);
    end
    v = '0; v.mem_rvalid = 1; v.mem_rdata = 32'h11;
    step(v, o, e);
    n_vec++;
    if (o !== e || o.if_rvalid !== 1'b1 || o.if_rdata !== 32'h11 || o.d_rvalid !== 1'b0) begin
      n_err++; $display("FAIL full_resp1 got %h want %h", o, e);
    end
    v.mem_rdata = 32'h22;
    step(v, o, e);
    n_vec++;
    if (o !== e || o.d_rvalid !== 1'b1 || o.d_rdata !== 32'h22 || o.if_rvalid !== 1'b0) begin
      n_err++; $display("FAIL full_resp2 got %h want %h", o, e);
    end
  endtask

  task automatic test_pop_push();
    drv_t v;
    out_t o, e;
    do_reset();
    v = '0; v.if_req = 1; v.if_addr = 32'h500; v.mem_ready = 1;
    step(v, o, e);
    step(v, o, e);
    v.mem_rvalid = 1; v.mem_rdata = 32'h77;
    step(v, o, e);
    n_vec++;
    if (o !== e || o.if_gnt !== 1'b1 || o.if_rvalid !== 1'b1) begin
      n_err++; $display("FAIL popush got %h want %h", o, e);
    end
    // still two outstanding: a new read must be refused
    v.mem_rvalid = 0;
    step(v, o, e);
    n_vec++;
    if (o !== e || o.if_gnt !== 1'b0) begin
      n_err++; $display("FAIL popush_full got %h want %h", o, e);
    end
    for (int i = 0; i < 2; i++) begin
      v = '0; v.mem_rvalid = 1; v.mem_rdata = 32'h80 + i;
      step(v, o, e);
      n_vec++;
      if (o !== e || o.if_rvalid !== 1'b1) begin
        n_err++; $display("FAIL popush_drain%0d got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_random();
    drv_t v;
    out_t o, e;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      v.if_req     = ($urandom_range(0, 9) < 7);
      v.if_addr    = $urandom;
      v.d_req      = ($urandom_range(0, 9) < 6);
      v.d_we       = $urandom_range(0, 1);
      v.d_wstrb    = 4'($urandom);
      v.d_addr     = $urandom;
      v.d_wdata    = $urandom;
      v.mem_ready  = ($urandom_range(0, 3) != 0);
      v.mem_rvalid = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      v.mem_rdata  = $urandom;
      step(v, o, e);
      n_vec++;
      if (o !== e) begin
        n_err++; $display("FAIL random_c%0d got %h want %h", c, o, e);
      end
    end
  endtask

  task automatic test_reset_orphan();
    drv_t v;
    out_t o, e;
    do_reset();
    v = '0; v.if_req = 1; v.if_addr = 32'h600; v.mem_ready = 1;
    step(v, o, e);
    drive('0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    v = '0; v.mem_rvalid = 1; v.mem_rdata = 32'h99;
    step(v, o, e);
    n_vec++;
    if (o !== e || o.if_rvalid !== 1'b0 || o.d_rvalid !== 1'b0) begin
      n_err++; $display("FAIL orphan_drop got %h want %h", o, e);
    end
    for (int c = 0; c < 3; c++) begin
      v = '0; v.if_req = (c == 1); v.mem_ready = 1;
      step(v, o, e);
      n_vec++;
      if (o !== e || o.resp_err !== 1'b1) begin
        n_err++; $display("FAIL orphan_sticky%0d got %h want %h", c, o, e);
      end
    end
  endtask

  initial begin
    drive('0);
    model_reset();
    test_reset();
    test_fetch_basic();
    test_data_priority();
    test_starvation();
    test_full();
    test_pop_push();
    test_random();
    test_reset_orphan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
